// File: rtl/fa_pkg.sv
// rtl/fa_pkg.sv - shared types, defaults and reference function for the registered full adder
package fa_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;

    typedef struct packed {
        logic c;
        logic s;
    } fa_bit_res_t;

    // Widest legal operand is 64 bits; callers slice [WIDTH:0] so bit WIDTH is the carry-out.
    function automatic logic [64:0] fa_ref(input logic [63:0] a, input logic [63:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {64'd0, cin};
    endfunction

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational 1-bit full adder cell
module fa_cell
    import fa_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    fa_bit_res_t res;

    always_comb begin
        res   = '0;
        res.s = a ^ b ^ ci;
        res.c = (a & b) | (a & ci) | (b & ci);
    end

    assign s  = res.s;
    assign co = res.c;

endmodule

// File: rtl/full_adder_reg.sv
// rtl/full_adder_reg.sv - ripple-carry adder of WIDTH fa_cells with a one-cycle output register
module full_adder_reg
    import fa_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             out_valid_q, out_valid_d;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // Idle cycles keep the last result so undriven operands never reach s/c.
    always_comb begin
        s_d         = s_q;
        c_d         = c_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            s_d         = sum;
            c_d         = carry[WIDTH];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign c         = c_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder_reg.sv
// tb/tb_full_adder_reg.sv - self-checking bench for full_adder_reg at WIDTH 1, 4 and 8
module tb_full_adder_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic       s1, c1, ov1;
    logic       iv4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [3:0] s4;
    logic       c4, ov4;
    logic       iv8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] s8;
    logic       c8, ov8;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    full_adder_reg #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
        .s(s1), .c(c1), .out_valid(ov1)
    );
    full_adder_reg #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4), .cin(cin4),
        .s(s4), .c(c4), .out_valid(ov4)
    );
    full_adder_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .cin(cin8),
        .s(s8), .c(c8), .out_valid(ov8)
    );

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic exp_c;
        logic exp_s;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] r1;
        logic [8:0] r8;
        logic [9:0] exp1;
        logic [9:0] exp8;
        logic [2:0] bits;

        vecs[0] = '{0, 0, 0, 0, 0};
        vecs[1] = '{0, 0, 1, 0, 1};
        vecs[2] = '{0, 1, 0, 0, 1};
        vecs[3] = '{0, 1, 1, 1, 0};
        vecs[4] = '{1, 0, 0, 0, 1};
        vecs[5] = '{1, 0, 1, 1, 0};
        vecs[6] = '{1, 1, 0, 1, 0};
        vecs[7] = '{1, 1, 1, 1, 1};

        tick();
        tick();
        chk("reset_w1", {ov1, c1, s1}, 3'b000);
        chk("reset_w4", {ov4, c4, s4}, 6'b000000);
        chk("reset_w8", {ov8, c8, s8}, 10'd0);

        #3 rst = 1'b0;

        // Exhaustive 1-bit table, back to back
        for (int i = 0; i < 8; i++) begin
            iv1 = 1'b1; a1 = vecs[i].a; b1 = vecs[i].b; cin1 = vecs[i].cin;
            tick();
            chk($sformatf("exh_%0d", i), {ov1, c1, s1}, {1'b1, vecs[i].exp_c, vecs[i].exp_s});
        end

        // Reset drops the in-flight result
        a1 = 1; b1 = 1; cin1 = 1; iv1 = 1;
        tick();
        chk("pre_reset", {ov1, c1, s1}, 3'b111);
        rst = 1'b1; iv1 = 1'b0;
        tick();
        chk("mid_reset", {ov1, c1, s1}, 3'b000);
        rst = 1'b0; iv1 = 1'b1; a1 = 1; b1 = 0; cin1 = 0;
        tick();
        chk("post_reset", {ov1, c1, s1}, 3'b101);

        // Hold while idle
        a1 = 1; b1 = 1; cin1 = 0; iv1 = 1;
        tick();
        chk("hold_load", {ov1, c1, s1}, 3'b110);
        iv1 = 0; a1 = 0; b1 = 0; cin1 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold_%0d", i), {ov1, c1, s1}, 3'b010);
        end

        // Reset wins over a same-edge valid input
        iv1 = 1; a1 = 1; b1 = 1; cin1 = 1; rst = 1'b1;
        tick();
        chk("rst_prio", {ov1, c1, s1}, 3'b000);
        rst = 1'b0; iv1 = 0;
        tick();
        chk("rst_prio_drop", {ov1, c1, s1}, 3'b000);

        // 4-bit carry ripple
        iv4 = 1; a4 = 4'hF; b4 = 4'h1; cin4 = 0;
        tick();
        chk("w4_ripple", {ov4, c4, s4}, {1'b1, 1'b1, 4'h0});
        a4 = 4'hF; b4 = 4'hF; cin4 = 1;
        tick();
        chk("w4_allones", {ov4, c4, s4}, {1'b1, 1'b1, 4'hF});
        a4 = 4'h0; b4 = 4'h0; cin4 = 0;
        tick();
        chk("w4_zero", {ov4, c4, s4}, {1'b1, 1'b0, 4'h0});
        iv4 = 0;

        // Random against the arithmetic model, starting from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp1 = '0;
        exp8 = '0;
        for (int n = 0; n < 1000; n++) begin
            bits = 3'($urandom);
            iv1 = ($urandom_range(0, 3) != 0); a1 = bits[0]; b1 = bits[1]; cin1 = bits[2];
            iv8 = ($urandom_range(0, 3) != 0); a8 = 8'($urandom); b8 = 8'($urandom);
            cin8 = 1'($urandom);
            r1 = 2'(a1) + 2'(b1) + 2'(cin1);
            r8 = 9'(a8) + 9'(b8) + 9'(cin8);
            if (iv1) exp1 = {8'd0, 1'b1, r1[1], r1[0]};
            else     exp1[2] = 1'b0;
            if (iv8) exp8 = {1'b1, r8};
            else     exp8[9] = 1'b0;
            tick();
            chk($sformatf("rand_w1_%0d", n), {ov1, c1, s1}, 64'(exp1[2:0]));
            chk($sformatf("rand_w8_%0d", n), {ov8, c8, s8}, 64'(exp8));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
